// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types, ALU opcode set and helpers for alu_arbiter
package alu_arbiter_pkg;

  localparam int OPS_W = 4;

  typedef enum logic [OPS_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SEQ = 4'd6,
    OP_SHL = 4'd7
  } op_mne;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    COND  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Driven while no op is in flight; ADD never writes the ALU Cond register
  localparam op_mne ALU_IDLE_OP = OP_ADD;

  function automatic logic is_cmp_op(input op_mne op);
    return (op == OP_SLT) || (op == OP_SEQ);
  endfunction

  function automatic logic is_legal_op(input logic [OPS_W-1:0] op);
    return op <= OP_SHL;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rtl/alu_arbiter_rr_arbiter.sv - combinational round-robin arbiter (ALU_ARB_PRIO_EN: requester 0 fixed priority)
module rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    if (en_i) begin
`ifdef ALU_ARB_PRIO_EN
      if (req_i[0]) begin
        gnt_o[0] = 1'b1;
        found    = 1'b1;
      end
`endif
      // Search starts just after the last winner so everyone gets a turn
      for (int k = 1; k <= NREQ; k++) begin
        j = (int'(ptr_i) + k) % NREQ;
        if (!found && req_i[j]) begin
          gnt_o[j] = 1'b1;
          idx_o    = IW'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU with registered Cond between NREQ requesters (ALU_ARB_PRIO_EN: requester 0 priority)
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W    = 8,
  parameter int Ops  = 4,
  parameter int NREQ = 4
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NREQ-1:0]           Req_valid,
  output logic [NREQ-1:0]           Req_ready,
  input  logic [NREQ*W-1:0]         Req_A,
  input  logic [NREQ*W-1:0]         Req_B,
  input  logic [NREQ*Ops-1:0]       Req_OP,
  output logic                      Resp_valid,
  input  logic                      Resp_ready,
  output logic [$clog2(NREQ)-1:0]   Resp_id,
  output logic [W-1:0]              Resp_out,
  output logic                      Resp_cond,
  output logic                      Resp_err,
  output logic [W-1:0]              Alu_A,
  output logic [W-1:0]              Alu_B,
  output logic [Ops-1:0]            Alu_OP,
  input  logic [W-1:0]              Alu_Out,
  input  logic                      Alu_Cond
);

  localparam int IW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [Ops-1:0]  op_q, op_d;
  logic [W-1:0]    out_q, out_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_cond_q, resp_cond_d;
  logic            resp_err_q, resp_err_d;
  logic [NREQ-1:0] shadow_q, shadow_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req_i (Req_valid),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign Req_ready  = gnt;
  assign Resp_valid = resp_valid_q;
  assign Resp_id    = id_q;
  assign Resp_out   = out_q;
  assign Resp_cond  = resp_cond_q;
  assign Resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    out_d        = out_q;
    resp_valid_d = resp_valid_q;
    resp_cond_d  = resp_cond_q;
    resp_err_d   = resp_err_q;
    shadow_d     = shadow_q;
    Alu_A        = '0;
    Alu_B        = '0;
    Alu_OP       = Ops'(ALU_IDLE_OP);

    case (state_q)
      IDLE: begin
        if (|gnt) begin
          a_d  = Req_A[int'(gnt_idx)*W +: W];
          b_d  = Req_B[int'(gnt_idx)*W +: W];
          op_d = Req_OP[int'(gnt_idx)*Ops +: Ops];
          id_d = gnt_idx;
`ifdef ALU_ARB_PRIO_EN
          // A priority win by requester 0 leaves the rotation untouched
          if (gnt_idx != '0) ptr_d = gnt_idx;
`else
          ptr_d = gnt_idx;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        Alu_A   = a_q;
        Alu_B   = b_q;
        Alu_OP  = op_q;
        out_d   = Alu_Out;
        state_d = COND;
      end
      COND: begin
        // Only compares own the Cond flag; everything else reports the requester's last compare
        if (is_cmp_op(op_mne'(op_q))) begin
          shadow_d[id_q] = Alu_Cond;
          resp_cond_d    = Alu_Cond;
        end else begin
          resp_cond_d = shadow_q[id_q];
        end
        resp_err_d   = !is_legal_op(op_q);
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (Resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= IW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      out_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_cond_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      out_q        <= out_d;
      resp_valid_q <= resp_valid_d;
      resp_cond_q  <= resp_cond_d;
      resp_err_q   <= resp_err_d;
      shadow_q     <= shadow_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W    = 8;
  localparam int OPSW = 4;
  localparam int NREQ = 4;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic [NREQ-1:0]       Req_valid;
  logic [NREQ-1:0]       Req_ready;
  logic [NREQ*W-1:0]     Req_A;
  logic [NREQ*W-1:0]     Req_B;
  logic [NREQ*OPSW-1:0]  Req_OP;
  logic                  Resp_valid;
  logic                  Resp_ready;
  logic [1:0]            Resp_id;
  logic [W-1:0]          Resp_out;
  logic                  Resp_cond;
  logic                  Resp_err;
  logic [W-1:0]          Alu_A;
  logic [W-1:0]          Alu_B;
  logic [OPSW-1:0]       Alu_OP;
  logic [W-1:0]          Alu_Out;
  logic                  Alu_Cond;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  alu_arbiter #(
    .W    (W),
    .Ops  (OPSW),
    .NREQ (NREQ)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Req_valid  (Req_valid),
    .Req_ready  (Req_ready),
    .Req_A      (Req_A),
    .Req_B      (Req_B),
    .Req_OP     (Req_OP),
    .Resp_valid (Resp_valid),
    .Resp_ready (Resp_ready),
    .Resp_id    (Resp_id),
    .Resp_out   (Resp_out),
    .Resp_cond  (Resp_cond),
    .Resp_err   (Resp_err),
    .Alu_A      (Alu_A),
    .Alu_B      (Alu_B),
    .Alu_OP     (Alu_OP),
    .Alu_Out    (Alu_Out),
    .Alu_Cond   (Alu_Cond)
  );

  // Behavioural ALU: combinational Out, Cond registered and written only by compares
  always_comb begin
    case (Alu_OP)
      OP_ADD:  Alu_Out = Alu_A + Alu_B;
      OP_SUB:  Alu_Out = Alu_A - Alu_B;
      OP_AND:  Alu_Out = Alu_A & Alu_B;
      OP_OR:   Alu_Out = Alu_A | Alu_B;
      OP_XOR:  Alu_Out = Alu_A ^ Alu_B;
      OP_SLT:  Alu_Out = {7'd0, Alu_A < Alu_B};
      OP_SEQ:  Alu_Out = {7'd0, Alu_A == Alu_B};
      OP_SHL:  Alu_Out = Alu_A << Alu_B[2:0];
      default: Alu_Out = 8'h00;
    endcase
  end

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              Alu_Cond <= 1'b0;
    else if (Alu_OP == OP_SLT) Alu_Cond <= (Alu_A < Alu_B);
    else if (Alu_OP == OP_SEQ) Alu_Cond <= (Alu_A == Alu_B);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    Req_valid[i]        = v;
    Req_OP[i*OPSW +: OPSW] = op;
    Req_A[i*W +: W]     = a;
    Req_B[i*W +: W]     = b;
  endtask

  task automatic wait_ready(input int i, input string tag);
    int n;
    n = 0;
    #1;
    while (Req_ready[i] !== 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    chk(tag, {28'd0, Req_ready}, 32'd1 << i);
  endtask

  task automatic txn(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp_out, input logic exp_cond, input logic exp_err,
                     input logic check_out, input string tag);
    set_req(i, 1'b1, op, a, b);
    wait_ready(i, {tag, "_ready"});
    tick(1);
    set_req(i, 1'b0, op, a, b);
    chk({tag, "_busy"}, {31'd0, Resp_valid}, 32'd0);
    tick(2);
    chk({tag, "_valid"}, {31'd0, Resp_valid}, 32'd1);
    chk({tag, "_id"}, {30'd0, Resp_id}, i);
    chk({tag, "_cond"}, {31'd0, Resp_cond}, {31'd0, exp_cond});
    chk({tag, "_err"}, {31'd0, Resp_err}, {31'd0, exp_err});
    if (check_out) chk({tag, "_out"}, {24'd0, Resp_out}, {24'd0, exp_out});
    tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] order [5];
    logic [7:0] rr_out [4];

    Reset_n    = 1'b0;
    Req_valid  = '0;
    Req_A      = '0;
    Req_B      = '0;
    Req_OP     = '0;
    Resp_ready = 1'b1;
    tick(2);
    chk("rst_resp_valid", {31'd0, Resp_valid}, 32'd0);
    chk("rst_resp_id", {30'd0, Resp_id}, 32'd0);
    chk("rst_resp_out", {24'd0, Resp_out}, 32'd0);
    chk("rst_resp_cond", {31'd0, Resp_cond}, 32'd0);
    chk("rst_resp_err", {31'd0, Resp_err}, 32'd0);
    chk("rst_req_ready", {28'd0, Req_ready}, 32'd0);
    chk("rst_alu_op", {28'd0, Alu_OP}, 32'd0);
    Reset_n = 1'b1;
    tick(1);

    // Single request, with a look at the ALU drive during ISSUE
    set_req(1, 1'b1, OP_ADD, 8'h05, 8'h03);
    wait_ready(1, "single_ready");
    tick(1);
    set_req(1, 1'b0, OP_ADD, 8'h05, 8'h03);
    chk("single_issue_a", {24'd0, Alu_A}, 32'h05);
    chk("single_issue_b", {24'd0, Alu_B}, 32'h03);
    chk("single_issue_valid", {31'd0, Resp_valid}, 32'd0);
    tick(2);
    chk("single_valid", {31'd0, Resp_valid}, 32'd1);
    chk("single_id", {30'd0, Resp_id}, 32'd1);
    chk("single_out", {24'd0, Resp_out}, 32'h08);
    chk("single_cond", {31'd0, Resp_cond}, 32'd0);
    chk("single_idle_alu_a", {24'd0, Alu_A}, 32'd0);
    tick(1);
    chk("single_done", {31'd0, Resp_valid}, 32'd0);

    // All four requesting continuously, fresh pointer
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
    tick(1);
`ifdef ALU_ARB_PRIO_EN
    order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    rr_out = '{8'h05, 8'h5A, 8'h0F, 8'h08};
    set_req(0, 1'b1, OP_SUB, 8'h09, 8'h04);
    set_req(1, 1'b1, OP_OR,  8'h50, 8'h0A);
    set_req(2, 1'b1, OP_XOR, 8'hF0, 8'hFF);
    set_req(3, 1'b1, OP_SHL, 8'h01, 8'h03);
    for (int k = 0; k < 5; k++) begin
      wait_ready(int'(order[k]), "rr_grant");
      tick(3);
      chk("rr_id", {30'd0, Resp_id}, {30'd0, order[k]});
      chk("rr_out", {24'd0, Resp_out}, {24'd0, rr_out[order[k]]});
      tick(1);
    end
    Req_valid = '0;

    // Cond flag stays private to each requester
    txn(0, OP_SLT, 8'h02, 8'h07, 8'h01, 1'b1, 1'b0, 1'b1, "iso_slt0");
    txn(2, OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1, "iso_add2");
    txn(2, OP_XOR, 8'h03, 8'h05, 8'h06, 1'b0, 1'b0, 1'b1, "iso_xor2");
    txn(0, OP_AND, 8'h0C, 8'h0A, 8'h08, 1'b1, 1'b0, 1'b1, "iso_and0");

    // Backpressure: response held, no new grant while a loser waits
    Resp_ready = 1'b0;
    set_req(3, 1'b1, OP_ADD, 8'h10, 8'h20);
    wait_ready(3, "bp_ready3");
    tick(1);
    set_req(3, 1'b0, OP_ADD, 8'h10, 8'h20);
    set_req(1, 1'b1, OP_ADD, 8'h01, 8'h02);
    tick(2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'd0, Resp_valid}, 32'd1);
      chk("bp_hold_out", {24'd0, Resp_out}, 32'h30);
      chk("bp_hold_id", {30'd0, Resp_id}, 32'd3);
      chk("bp_no_grant", {28'd0, Req_ready}, 32'd0);
      tick(1);
    end
    Resp_ready = 1'b1;
    tick(1);
    chk("bp_release_valid", {31'd0, Resp_valid}, 32'd0);
    chk("bp_next_grant", {28'd0, Req_ready}, 32'b0010);
    tick(1);
    set_req(1, 1'b0, OP_ADD, 8'h01, 8'h02);
    tick(2);
    chk("bp_next_id", {30'd0, Resp_id}, 32'd1);
    chk("bp_next_out", {24'd0, Resp_out}, 32'h03);
    tick(1);

    // Reset while an op sits in COND
    txn(0, OP_SLT, 8'h01, 8'h09, 8'h01, 1'b1, 1'b0, 1'b1, "mr_slt0");
    set_req(0, 1'b1, OP_ADD, 8'h04, 8'h04);
    wait_ready(0, "mr_ready0");
    tick(2);
    Reset_n = 1'b0;
    #1;
    chk("mr_rst_valid", {31'd0, Resp_valid}, 32'd0);
    chk("mr_rst_cond", {31'd0, Resp_cond}, 32'd0);
    set_req(2, 1'b1, OP_ADD, 8'h06, 8'h06);
    tick(1);
    Reset_n = 1'b1;
    #1;
    chk("mr_first_grant", {28'd0, Req_ready}, 32'b0001);
    tick(1);
    set_req(0, 1'b0, OP_ADD, 8'h04, 8'h04);
    tick(2);
    chk("mr_regrant_id", {30'd0, Resp_id}, 32'd0);
    chk("mr_regrant_out", {24'd0, Resp_out}, 32'h08);
    chk("mr_shadow_cleared", {31'd0, Resp_cond}, 32'd0);
    tick(1);
    txn(2, OP_ADD, 8'h06, 8'h06, 8'h0C, 1'b0, 1'b0, 1'b1, "mr_req2");

    // Illegal opcode flags an error; the next legal op clears it
    txn(1, 4'hC, 8'h03, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, "illegal");
    txn(1, OP_SUB, 8'h09, 8'h02, 8'h07, 1'b0, 1'b0, 1'b1, "legal_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
